// File: rtl/m_imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit instruction-memory writes
// and holds the processor in reset until the image is complete. Optional checksum: IMEM_LOADER_CKSUM_EN.
module m_imem_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_valid,
    input  logic [7:0]        w_data,
    output logic              w_ready,
    input  logic              w_restart,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [31:0]       r_wdata,
    output logic              r_proc_rst,
    output logic              r_done,
    output logic              r_err,
    output logic [2:0]        r_dbg_state
);

    typedef enum logic [2:0] {
        S_CNT0 = 3'd0,
        S_CNT1 = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_LOADER_CKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [15:0] word_cnt;
    logic [15:0] count;
    logic [23:0] word_buf;
    logic [15:0] count_full;
    logic        xfer;
    logic        last_word;
    logic        restart;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]  sum;
    logic [7:0]  sum_chk;
    assign sum_chk = sum + w_data;
`endif

    // Valid/ready: a byte moves on a rising edge where w_valid && w_ready; w_ready depends
    // only on state, so the source may hold w_valid high indefinitely in DONE/ERR.
    assign xfer        = w_valid && w_ready;
    assign count_full  = {w_data, count[7:0]};
    assign last_word   = (word_cnt == (count - 16'd1));
    assign restart     = ((state == S_DONE) || (state == S_ERR)) && w_restart;
    assign r_dbg_state = state;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) state <= S_CNT0;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        case (state)
            S_CNT0: begin
                w_ready = 1'b1;
                if (xfer) state_nxt = S_CNT1;
            end
            S_CNT1: begin
                w_ready = 1'b1;
                if (xfer) begin
                    if (count_full == 16'd0)
`ifdef IMEM_LOADER_CKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    else if ({1'b0, count_full} > DEPTH_L)
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_ready = 1'b1;
                if (xfer && (byte_cnt == 2'd3) && last_word)
`ifdef IMEM_LOADER_CKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CSUM: begin
                w_ready = 1'b1;
                if (xfer) state_nxt = (sum_chk == 8'h00) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (w_restart) state_nxt = S_CNT0;
            end
            default: state_nxt = S_CNT0;
        endcase
    end

    // Status outputs are registered from the next state so they change with the final write.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_proc_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            count      <= '0;
            word_buf   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum        <= '0;
`endif
        end else begin
            r_we       <= 1'b0;
            r_done     <= (state_nxt == S_DONE);
            r_err      <= (state_nxt == S_ERR);
            r_proc_rst <= (state_nxt != S_DONE);
            if (restart) begin
                byte_cnt <= '0;
                word_cnt <= '0;
                count    <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
                sum      <= '0;
`endif
            end else if (xfer) begin
                case (state)
                    S_CNT0: count[7:0]  <= w_data;
                    S_CNT1: count[15:8] <= w_data;
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                        sum      <= sum + w_data;
`endif
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= w_data;
                            2'd1: word_buf[15:8]  <= w_data;
                            2'd2: word_buf[23:16] <= w_data;
                            default: begin
                                r_we     <= 1'b1;
                                r_addr   <= word_cnt[ADDR_W-1:0];
                                r_wdata  <= {w_data, word_buf};
                                word_cnt <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m_imem_loader.sv
// Bench for m_imem_loader: table-driven byte vectors plus hand sequences; memory writes are
// checked against an expected queue. Checksum cases follow IMEM_LOADER_CKSUM_EN.
module tb_m_imem_loader;

    localparam int AW = 12;
    localparam int W  = AW + 32;

    logic          w_clk = 1'b0;
    logic          w_rst_n = 1'b0;
    logic          w_valid = 1'b0;
    logic [7:0]    w_data = 8'h00;
    logic          w_ready;
    logic          w_restart = 1'b0;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_proc_rst;
    logic          r_done;
    logic          r_err;
    logic [2:0]    r_dbg_state;

    m_imem_loader #(.ADDR_W(AW), .DEPTH(4096)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .w_restart(w_restart), .r_we(r_we), .r_addr(r_addr),
        .r_wdata(r_wdata), .r_proc_rst(r_proc_rst), .r_done(r_done), .r_err(r_err),
        .r_dbg_state(r_dbg_state)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [7:0] data;
        logic       exp_ready;
        logic       exp_done;
        logic       exp_err;
        logic       exp_prst;
    } vec_t;

    vec_t        vecs[$];
    logic [W-1:0] exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected {addr, data}.
    always @(negedge w_clk) begin
        if (w_rst_n === 1'b1 && r_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {r_addr, r_wdata}, '0);
                if ({r_addr, r_wdata} == '0) check("unexpected_write_zero", 64'd1, 64'd0);
            end else begin
                check("write", {r_addr, r_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic add(input logic [7:0] d, input logic rdy, input logic dn, input logic er,
                       input logic pr);
        vec_t v;
        v.data = d; v.exp_ready = rdy; v.exp_done = dn; v.exp_err = er; v.exp_prst = pr;
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge w_clk);
            w_valid = 1'b1;
            w_data  = vecs[i].data;
            check($sformatf("vec%0d_ready", i), w_ready, vecs[i].exp_ready);
            @(posedge w_clk);
            #1;
            check($sformatf("vec%0d_done", i), r_done, vecs[i].exp_done);
            check($sformatf("vec%0d_err", i), r_err, vecs[i].exp_err);
            check($sformatf("vec%0d_prst", i), r_proc_rst, vecs[i].exp_prst);
        end
        vecs.delete();
        @(negedge w_clk);
        w_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge w_clk);
        w_valid = 1'b1;
        w_data  = b;
        @(posedge w_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge w_clk);
            w_valid = 1'b0;
        end
    endtask

    task automatic do_restart(input string name);
        @(negedge w_clk);
        w_valid   = 1'b0;
        w_restart = 1'b1;
        @(posedge w_clk);
        #1;
        check({name, "_done"}, r_done, 1'b0);
        check({name, "_err"}, r_err, 1'b0);
        check({name, "_prst"}, r_proc_rst, 1'b1);
        check({name, "_ready"}, w_ready, 1'b1);
        @(negedge w_clk);
        w_restart = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_we"}, r_we, 1'b0);
        check({name, "_addr"}, r_addr, '0);
        check({name, "_wdata"}, r_wdata, '0);
        check({name, "_prst"}, r_proc_rst, 1'b1);
        check({name, "_done"}, r_done, 1'b0);
        check({name, "_err"}, r_err, 1'b0);
        check({name, "_ready"}, w_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] img[$];
        repeat (3) @(negedge w_clk);
        check_reset_outputs("reset");
        w_rst_n = 1'b1;

        // Two-word image, back-to-back bytes.
        exp_q.push_back({12'd0, 32'h0000_0020});
        exp_q.push_back({12'd1, 32'h2008_1004});
        img = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h08};
        foreach (img[i]) add(img[i], 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CKSUM_EN
        add(8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        add(8'hA4, 1'b1, 1'b1, 1'b0, 1'b0);
`else
        add(8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        run_vecs();
        idle(2);
        check("b2b_drained", exp_q.size(), 0);
        check("done_ready_low", w_ready, 1'b0);
        // A held byte in DONE is not consumed and changes nothing.
        send_byte(8'hFF);
        send_byte(8'hFF);
        check("done_hold_done", r_done, 1'b1);
        check("done_hold_prst", r_proc_rst, 1'b0);
        idle(1);

        // Same image with a bubble after every byte.
        do_restart("restart1");
        exp_q.push_back({12'd0, 32'h0000_0020});
        exp_q.push_back({12'd1, 32'h2008_1004});
        img = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h08, 8'h20};
`ifdef IMEM_LOADER_CKSUM_EN
        img.push_back(8'hA4);
`endif
        foreach (img[i]) begin
            send_byte(img[i]);
            idle(1);
            if (i < img.size() - 1) check($sformatf("gap%0d_ready", i), w_ready, 1'b1);
        end
        idle(1);
        check("gap_done", r_done, 1'b1);
        check("gap_prst", r_proc_rst, 1'b0);
        check("gap_drained", exp_q.size(), 0);

        // Count above DEPTH.
        do_restart("restart2");
        send_byte(8'h01);
        send_byte(8'h10);
        idle(1);
        check("ovf_err", r_err, 1'b1);
        check("ovf_prst", r_proc_rst, 1'b1);
        check("ovf_done", r_done, 1'b0);
        check("ovf_ready", w_ready, 1'b0);
        idle(2);
        do_restart("restart3");

        // Empty image.
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CKSUM_EN
        check("zero_csum_wait", r_done, 1'b0);
        send_byte(8'h00);
`endif
        idle(1);
        check("zero_done", r_done, 1'b1);
        check("zero_prst", r_proc_rst, 1'b0);
        do_restart("restart4");

        // Count exactly DEPTH is accepted, then abandoned by reset.
        send_byte(8'h00);
        send_byte(8'h10);
        idle(1);
        check("depth_err", r_err, 1'b0);
        check("depth_ready", w_ready, 1'b1);
        #2 w_rst_n = 1'b0;
        @(negedge w_clk);
        w_rst_n = 1'b1;

        // Reset after five bytes of a two-word load.
        img = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        foreach (img[i]) send_byte(img[i]);
        idle(1);
        #2 w_rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge w_clk);
        w_rst_n = 1'b1;
        exp_q.push_back({12'd0, 32'h4433_2211});
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef IMEM_LOADER_CKSUM_EN
        img.push_back(8'h56);
`endif
        foreach (img[i]) send_byte(img[i]);
        idle(2);
        check("fresh_done", r_done, 1'b1);
        check("fresh_drained", exp_q.size(), 0);

`ifdef IMEM_LOADER_CKSUM_EN
        // Checksum good and bad.
        do_restart("restart5");
        exp_q.push_back({12'd0, 32'h0403_0201});
        img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        foreach (img[i]) send_byte(img[i]);
        idle(1);
        check("csum_ok_done", r_done, 1'b1);
        check("csum_ok_err", r_err, 1'b0);
        do_restart("restart6");
        exp_q.push_back({12'd0, 32'h0403_0201});
        img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        foreach (img[i]) send_byte(img[i]);
        idle(1);
        check("csum_bad_err", r_err, 1'b1);
        check("csum_bad_done", r_done, 1'b0);
        check("csum_bad_prst", r_proc_rst, 1'b1);
`endif

        idle(3);
        check("final_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
